// File: rtl/pointwise_pkg.sv
// -----------------------------------------------------------------------------
// pointwise_pkg
// Shared widths and helpers for the pointwise accumulator slice.
//   - lane width, channel parallelism, accumulator guard bits, FIFO depth
//   - sat_to_data   : clamp an accumulator value to the signed lane range
//   - is_last_group : true when a group base is the final group of a count
// The lane and accumulator widths are fixed here for the whole slice.
// -----------------------------------------------------------------------------
package pointwise_pkg;

  localparam int DATA_WIDTH             = 16;
  localparam int INCHANNEL_PARALLELISM  = 8;
  localparam int OUTCHANNEL_PARALLELISM = 8;
  localparam int ACC_GUARD              = 4;
  localparam int FIFO_DEPTH             = 4;

  localparam int ACC_WIDTH   = DATA_WIDTH + ACC_GUARD;
  localparam int FEAT_WIDTH  = DATA_WIDTH * OUTCHANNEL_PARALLELISM;
  // FIFO entry layout: {last_oc, oc_sel[7:0], feature}
  localparam int ENTRY_WIDTH = FEAT_WIDTH + 8 + 1;

  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [DATA_WIDTH-1:0] data_t;

  localparam acc_t SAT_MAX = {{(ACC_GUARD + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_GUARD + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  function automatic data_t sat_to_data(input acc_t value);
    if (value > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (value < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return value[DATA_WIDTH-1:0];
  endfunction

  // A group is last when the whole count fits in one group, or when its base
  // reaches the start of the final group. The guard keeps count-par from
  // underflowing.
  function automatic logic is_last_group(input logic [7:0] count,
                                         input logic [7:0] sel,
                                         input logic [7:0] par);
    return (count <= par) || (sel >= count - par);
  endfunction

endpackage

// File: rtl/pointwise_out_fifo.sv
// -----------------------------------------------------------------------------
// pointwise_out_fifo
// Synchronous FIFO with a registered head. The head register only changes on a
// pop or on a push into an empty FIFO, so it holds steady while stalled.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush (pointers, count, head to zero)
//   push, push_data : write request and data
//   pop         : consumer takes the head (ignored when empty)
//   head_data   : current head entry
//   full, empty, count : occupancy
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module pointwise_out_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_fire, pop_fire;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise a latch is inferred.
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop_fire  = pop && !empty;
    push_fire = push && (!full || pop_fire);
    rd_next   = rd_ptr_q + PTR_W'(1);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;

    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_fire)  rd_ptr_d = rd_next;

    unique case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head refill: the next stored entry if one exists, otherwise the entry
    // being pushed this cycle (pass-through into an empty FIFO).
    if (pop_fire) begin
      if (count_q > CNT_W'(1)) head_d = mem_q[rd_next];
      else if (push_fire)      head_d = push_data;
    end else if (push_fire && empty) begin
      head_d = push_data;
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage has no reset; it is never read before being written because
  // count gates every read, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_fire && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = head_q;
  assign count     = count_q;

endmodule

// File: rtl/pointwise_accum.sv
// -----------------------------------------------------------------------------
// pointwise_accum
// Receives the pointwise convolution partial stream, sums partials across
// input-channel groups per output lane, saturates finished groups to the lane
// width and queues them for the next stage over valid/ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle layer restart (wins over in_valid)
//   input_channel, output_channel, output_size : layer shape
//   in_valid, in_feature, in_ic_sel, in_oc_sel : partial-result beat
//   out_valid, out_ready, out_feature, out_oc_sel, out_last : output stream
//   pixel_cnt           : pixels fully emitted since start
//   layer_done          : pulse after the final group of the final pixel
//   overflow            : sticky, a finished group was dropped on a full FIFO
// Build option: define POINTWISE_ACCUM_RELU_EN to clamp negative results to 0.
// -----------------------------------------------------------------------------
module pointwise_accum
  import pointwise_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            input_channel,
  input  logic [7:0]            output_channel,
  input  logic [7:0]            output_size,
  input  logic                  in_valid,
  input  logic [FEAT_WIDTH-1:0] in_feature,
  input  logic [7:0]            in_ic_sel,
  input  logic [7:0]            in_oc_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FEAT_WIDTH-1:0] out_feature,
  output logic [7:0]            out_oc_sel,
  output logic                  out_last,
  output logic [15:0]           pixel_cnt,
  output logic                  layer_done,
  output logic                  overflow
);

  localparam int LANES = OUTCHANNEL_PARALLELISM;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  acc_t  acc_q [LANES];
  acc_t  acc_d [LANES];
  acc_t  lane_sum [LANES];
  data_t lane_in  [LANES];
  data_t lane_sat [LANES];

  logic [FEAT_WIDTH-1:0]  push_feature;
  logic [ENTRY_WIDTH-1:0] push_entry, head_entry;
  logic                   is_first, is_last_ic, is_last_oc;
  logic                   push, pop_fire;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [15:0]            pixel_total;
  logic [15:0]            pixel_cnt_q, pixel_cnt_d;
  logic                   layer_done_q, layer_done_d;
  logic                   overflow_q, overflow_d;

  // Beat classification and per-lane accumulate / finish path.
  always_comb begin
    is_first     = (in_ic_sel == '0);
    is_last_ic   = is_last_group(input_channel, in_ic_sel, 8'(INCHANNEL_PARALLELISM));
    is_last_oc   = is_last_group(output_channel, in_oc_sel, 8'(OUTCHANNEL_PARALLELISM));
    push         = in_valid && is_last_ic && !start;
    push_feature = '0;

    for (int i = 0; i < LANES; i++) begin
      lane_in[i]  = in_feature[DATA_WIDTH*i +: DATA_WIDTH];
      // A first group starts from zero; a stray non-first group without a
      // preceding first simply adds onto whatever acc holds.
      lane_sum[i] = (is_first ? acc_t'(0) : acc_q[i])
                  + {{ACC_GUARD{lane_in[i][DATA_WIDTH-1]}}, lane_in[i]};
      lane_sat[i] = sat_to_data(lane_sum[i]);
`ifdef POINTWISE_ACCUM_RELU_EN
      if (lane_sat[i][DATA_WIDTH-1]) lane_sat[i] = '0;
`endif
      push_feature[DATA_WIDTH*i +: DATA_WIDTH] = lane_sat[i];

      acc_d[i] = acc_q[i];
      if (start)         acc_d[i] = '0;
      // The accumulator clears after a last group even if the FIFO drops it.
      else if (in_valid) acc_d[i] = is_last_ic ? acc_t'(0) : lane_sum[i];
    end

    push_entry = {is_last_oc, in_oc_sel, push_feature};
  end

  pointwise_out_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop_fire    = out_ready && !fifo_empty && !start;
  assign out_valid   = (fifo_count != '0);
  assign out_feature = head_entry[FEAT_WIDTH-1:0];
  assign out_oc_sel  = head_entry[FEAT_WIDTH +: 8];
  assign out_last    = head_entry[ENTRY_WIDTH-1];

  // Pixel progress, completion pulse and sticky overflow.
  always_comb begin
    pixel_total  = 16'(output_size) * 16'(output_size);
    pixel_cnt_d  = pixel_cnt_q;
    layer_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (start) begin
      pixel_cnt_d = '0;
      overflow_d  = 1'b0;
    end else begin
      // Counting stops once the layer's pixel total is reached.
      if (pop_fire && out_last && (pixel_cnt_q < pixel_total)) begin
        pixel_cnt_d  = pixel_cnt_q + 16'd1;
        layer_done_d = (pixel_cnt_q + 16'd1 == pixel_total);
      end
      if (push && fifo_full && !pop_fire) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      pixel_cnt_q  <= '0;
      layer_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
      pixel_cnt_q  <= pixel_cnt_d;
      layer_done_q <= layer_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pixel_cnt  = pixel_cnt_q;
  assign layer_done = layer_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pointwise_accum.sv
`timescale 1ns/1ps
module tb_pointwise_accum;

  localparam int DW    = 16;
  localparam int LANES = 8;
  localparam int FW    = DW * LANES;

  typedef int lanes_t [LANES];
  typedef struct {
    logic [FW-1:0] feat;
    logic [7:0]    oc;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    input_channel, output_channel, output_size;
  logic          in_valid;
  logic [FW-1:0] in_feature;
  logic [7:0]    in_ic_sel, in_oc_sel;
  logic          out_valid, out_ready;
  logic [FW-1:0] out_feature;
  logic [7:0]    out_oc_sel;
  logic          out_last;
  logic [15:0]   pixel_cnt;
  logic          layer_done, overflow;

  exp_t sb[$];
  int   model_acc [LANES];
  int   cur_ic = 8;
  int   cur_oc = 8;
  int   errors = 0;
  int   checks = 0;
  int   ld_count = 0;

  pointwise_accum dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .input_channel  (input_channel),
    .output_channel (output_channel),
    .output_size    (output_size),
    .in_valid       (in_valid),
    .in_feature     (in_feature),
    .in_ic_sel      (in_ic_sel),
    .in_oc_sel      (in_oc_sel),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_feature    (out_feature),
    .out_oc_sel     (out_oc_sel),
    .out_last       (out_last),
    .pixel_cnt      (pixel_cnt),
    .layer_done     (layer_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    int r;
    r = v;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`ifdef POINTWISE_ACCUM_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // One clock: check any handshake at the falling edge against the scoreboard,
  // then advance to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready && !start) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL handshake_unexpected: got entry oc_sel=%0d, expected none", out_oc_sel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (out_feature !== e.feat) begin
          errors++;
          $display("FAIL head_feature: got %h, expected %h", out_feature, e.feat);
        end
        checks++;
        if (out_oc_sel !== e.oc || out_last !== e.last) begin
          errors++;
          $display("FAIL head_tag: got oc_sel=%0d last=%b, expected oc_sel=%0d last=%b",
                   out_oc_sel, out_last, e.oc, e.last);
        end
      end
    end
    if (layer_done === 1'b1) ld_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_layer(input int ic, input int oc, input int os);
    cur_ic = ic; cur_oc = oc;
    input_channel = 8'(ic); output_channel = 8'(oc); output_size = 8'(os);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.delete();
    for (int i = 0; i < LANES; i++) model_acc[i] = 0;
  endtask

  // Drive one beat for one cycle; the model predicts the finished entry.
  task automatic send_beat(input int ic_sel, input int oc_sel, input lanes_t v, input bit drop);
    bit   first, last;
    exp_t e;
    first = (ic_sel == 0);
    last  = (cur_ic <= 8) || (ic_sel >= cur_ic - 8);
    in_valid  = 1'b1;
    in_ic_sel = 8'(ic_sel);
    in_oc_sel = 8'(oc_sel);
    for (int i = 0; i < LANES; i++) begin
      in_feature[DW*i +: DW] = 16'(v[i]);
      model_acc[i] = first ? v[i] : model_acc[i] + v[i];
    end
    if (last) begin
      for (int i = 0; i < LANES; i++) begin
        e.feat[DW*i +: DW] = 16'(sat(model_acc[i]));
        model_acc[i] = 0;
      end
      e.oc   = 8'(oc_sel);
      e.last = (cur_oc <= 8) || (oc_sel >= cur_oc - 8);
      if (!drop) sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending, expected 0", sb.size());
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    expect_bit("reset_out_valid", out_valid, 1'b0);
    expect_bit("reset_out_last", out_last, 1'b0);
    expect_bit("reset_layer_done", layer_done, 1'b0);
    expect_bit("reset_overflow", overflow, 1'b0);
    expect_val("reset_pixel_cnt", 32'(pixel_cnt), 0);
    expect_val("reset_out_oc_sel", 32'(out_oc_sel), 0);
    checks++;
    if (out_feature !== '0) begin
      errors++;
      $display("FAIL reset_out_feature: got %h, expected 0", out_feature);
    end
  endtask

  task automatic test_accumulate();
    lanes_t v;
    set_layer(32, 8, 16);
    do_start();
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      v[0] = 100 * (g + 1);
      for (int i = 1; i < LANES; i++) v[i] = i * 11 - 20 + g;
      send_beat(g * 8, 0, v, 1'b0);
    end
    // Last beat landed on the previous edge: entry must already be visible.
    expect_bit("accum_visible_next_cycle", out_valid, 1'b1);
    expect_val("accum_lane0", 32'(out_feature[15:0]), 1000);
    drain();
    expect_val("accum_pixel_cnt", 32'(pixel_cnt), 1);
  endtask

  task automatic test_saturation();
    lanes_t v;
    set_layer(16, 8, 16);
    do_start();
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) v[i] = (i % 2 == 0) ? 30000 : -1000 * i;
    send_beat(0, 0, v, 1'b0);
    send_beat(8, 0, v, 1'b0);
    expect_val("sat_pos_lane0", 32'(out_feature[15:0]), 32'h7FFF);
    drain();
    for (int i = 0; i < LANES; i++) v[i] = (i % 2 == 0) ? -30000 : 500 * i;
    send_beat(0, 0, v, 1'b0);
    send_beat(8, 0, v, 1'b0);
`ifdef POINTWISE_ACCUM_RELU_EN
    expect_val("sat_neg_lane0", 32'(out_feature[15:0]), 0);
`else
    expect_val("sat_neg_lane0", 32'(out_feature[15:0]), 32'h8000);
`endif
    drain();
  endtask

  task automatic test_back_to_back_oc();
    lanes_t v;
    set_layer(8, 64, 16);
    do_start();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = k * 100 + i - 3;
      send_beat(0, k * 8, v, 1'b0);
    end
    drain();
    expect_val("oc_groups_pixel_cnt", 32'(pixel_cnt), 1);
  endtask

  task automatic test_full_push_pop();
    lanes_t v;
    set_layer(8, 8, 16);
    do_start();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = 40 * k - i;
      send_beat(0, 0, v, 1'b0);
    end
    expect_bit("fullpp_valid", out_valid, 1'b1);
    expect_bit("fullpp_no_overflow_yet", overflow, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) v[i] = 777 + i;
    send_beat(0, 0, v, 1'b0);
    expect_bit("fullpp_overflow", overflow, 1'b0);
    drain();
    expect_val("fullpp_pixel_cnt", 32'(pixel_cnt), 5);
  endtask

  task automatic test_overflow();
    lanes_t       v;
    logic [FW-1:0] first_head;
    set_layer(8, 8, 16);
    do_start();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = (k + 1) * 10 + i;
      send_beat(0, 0, v, k == 4);
      if (k == 3) expect_bit("ovf_before_fifth", overflow, 1'b0);
    end
    first_head = sb[0].feat;
    expect_bit("ovf_set", overflow, 1'b1);
    checks++;
    if (out_feature !== first_head) begin
      errors++;
      $display("FAIL ovf_head_stable: got %h, expected %h", out_feature, first_head);
    end
    expect_val("ovf_queued", 32'(sb.size()), 4);
    out_ready = 1'b1;
    drain();
    tick();
    expect_bit("ovf_valid_after_drain", out_valid, 1'b0);
    expect_bit("ovf_sticky", overflow, 1'b1);
    expect_val("ovf_pixel_cnt", 32'(pixel_cnt), 4);
  endtask

  task automatic test_layer_done();
    lanes_t v;
    int     ld_base;
    set_layer(8, 8, 2);
    do_start();
    ld_base   = ld_count;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) v[i] = k - i * 3;
      send_beat(0, 0, v, 1'b0);
    end
    drain();
    expect_bit("done_pulse_after_last_hs", layer_done, 1'b1);
    expect_val("done_pixel_cnt", 32'(pixel_cnt), 4);
    tick();
    expect_bit("done_pulse_one_cycle", layer_done, 1'b0);
    send_beat(0, 0, v, 1'b0);
    drain();
    tick();
    tick();
    expect_val("done_pixel_cnt_holds", 32'(pixel_cnt), 4);
    expect_val("done_pulse_count", 32'(ld_count - ld_base), 1);
  endtask

  task automatic test_start_mid();
    lanes_t v;
    set_layer(8, 8, 16);
    do_start();
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) v[i] = i + 1;
    send_beat(0, 0, v, 1'b0);
    drain();
    expect_val("startmid_pre_pixel", 32'(pixel_cnt), 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(0, 0, v, k == 4);
    expect_bit("startmid_pre_overflow", overflow, 1'b1);
    set_layer(32, 8, 16);
    for (int i = 0; i < LANES; i++) v[i] = 50;
    send_beat(0, 0, v, 1'b0);
    // start and a beat in the same cycle: the beat must be ignored.
    in_valid  = 1'b1;
    in_ic_sel = 8'd8;
    for (int i = 0; i < LANES; i++) in_feature[DW*i +: DW] = 16'd1000;
    do_start();
    in_valid = 1'b0;
    expect_bit("startmid_valid", out_valid, 1'b0);
    expect_bit("startmid_overflow", overflow, 1'b0);
    expect_val("startmid_pixel", 32'(pixel_cnt), 0);
    checks++;
    if (out_feature !== '0) begin
      errors++;
      $display("FAIL startmid_feature: got %h, expected 0", out_feature);
    end
    // Non-first groups after start must build on a cleared accumulator.
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) v[i] = 7 + i;
    send_beat(16, 0, v, 1'b0);
    for (int i = 0; i < LANES; i++) v[i] = 9 - i;
    send_beat(24, 0, v, 1'b0);
    expect_val("startmid_acc_cleared_lane0", 32'(out_feature[15:0]), 16);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_feature = '0; in_ic_sel = '0; in_oc_sel = '0;
    set_layer(8, 8, 16);
    for (int i = 0; i < LANES; i++) model_acc[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_reset();
    test_accumulate();
    test_saturation();
    test_back_to_back_oc();
    test_full_push_pop();
    test_overflow();
    test_layer_done();
    test_start_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
